// File: rtl/mathco_seq_if.sv
// mathco_seq_if: HuCard math-window bus seen by the coprocessor.
//   bus_ce   - window select, active high
//   bus_a    - byte offset within the window
//   bus_we_n - CPU write strobe, active low, asynchronous to CLK
//   bus_dato - CPU write data
//   bus_dati - read data back to the CPU
// master modport drives the strobes (CPU / bench side); slave modport is the coprocessor.
interface mathco_seq_if;
  logic       bus_ce;
  logic [4:0] bus_a;
  logic       bus_we_n;
  logic [7:0] bus_dato;
  logic [7:0] bus_dati;

  modport master (
    output bus_ce, bus_a, bus_we_n, bus_dato,
    input  bus_dati
  );

  modport slave (
    input  bus_ce, bus_a, bus_we_n, bus_dato,
    output bus_dati
  );
endinterface

// File: rtl/mathco_seq.sv
// mathco_seq: math coprocessor for the cartridge register window.
// Synchronises CPU writes into CLK, holds operand/result/control registers and runs one shared
// 32-iteration datapath: shift-add unsigned multiply or restoring unsigned divide.
// Ports:
//   CLK   - system clock
//   RSTn  - asynchronous active-low reset
//   bus   - window bus (slave modport): select, offset, write strobe/data, read data
//   busy  - operation in progress (RUN or FIN)
//   irq_n - active-low interrupt, asserted while done and irq_en are both set
module mathco_seq #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         CLK,
  input  logic         RSTn,
  mathco_seq_if.slave  bus,
  output logic         busy,
  output logic         irq_n
);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic       we_s, we_s_q, we_rise, commit;
  logic [1:0] low_run_q;
  logic [4:0] lat_a_q;
  logic [7:0] lat_d_q;

  logic [31:0] a_q, b_q, wb_q;
  logic [63:0] r_q, acc_q;
  logic [4:0]  ctr_q;
  logic        op_q, wop_q, irq_en_q, start_q, done_q, dz_q;
  logic        load, load_dz;

  logic [32:0] mul_sum;
  logic [63:0] mul_next, div_next;
  logic [33:0] div_trial;

  // Strobe synchroniser; idles high so reset release never looks like a write edge.
  assign we_s    = sync_q[SYNC_STAGES-1];
  assign we_rise = we_s & ~we_s_q;
  // Require two consecutive low samples so a glitch-length strobe cannot commit.
  assign commit  = we_rise & (low_run_q == 2'd2);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync_q    <= '1;
      we_s_q    <= 1'b1;
      low_run_q <= 2'd0;
      lat_a_q   <= 5'd0;
      lat_d_q   <= 8'd0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.bus_we_n | ~bus.bus_ce};
      we_s_q <= we_s;
      if (we_s) begin
        low_run_q <= 2'd0;
      end else begin
        lat_a_q <= bus.bus_a;
        lat_d_q <= bus.bus_dato;
        if (low_run_q != 2'd2) low_run_q <= low_run_q + 2'd1;
      end
    end
  end

  // Datapath step for one iteration.
  assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, wb_q} : 33'd0);
  assign mul_next  = {mul_sum, acc_q[31:1]};
  assign div_trial = {1'b0, acc_q[63:31]} - {2'b00, wb_q};
  assign div_next  = div_trial[33] ? {acc_q[62:0], 1'b0}
                                   : {div_trial[31:0], acc_q[30:0], 1'b1};

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    load_dz = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_q) begin
          if (op_q && (b_q == 32'd0)) begin
            state_d = StFin;
            load_dz = 1'b1;
          end else begin
            state_d = StRun;
            load    = 1'b1;
          end
        end
      end
      StRun:   if (ctr_q == 5'd31) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      acc_q    <= '0;
      wb_q     <= '0;
      ctr_q    <= '0;
      op_q     <= 1'b0;
      wop_q    <= 1'b0;
      irq_en_q <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      // start is a one-cycle pulse; a start seen outside IDLE is simply dropped.
      start_q <= commit && (lat_a_q == 5'h10) && lat_d_q[0];
      if (commit) begin
        if (lat_a_q[4:2] == 3'b000) a_q[{lat_a_q[1:0], 3'b000} +: 8] <= lat_d_q;
        if (lat_a_q[4:2] == 3'b001) b_q[{lat_a_q[1:0], 3'b000} +: 8] <= lat_d_q;
        if (lat_a_q == 5'h10) begin
          op_q     <= lat_d_q[1];
          irq_en_q <= lat_d_q[3];
        end
      end

      // FIN setting done has priority over a same-cycle STATUS write.
      if (state_q == StFin)                   done_q <= 1'b1;
      else if (load || load_dz)               done_q <= 1'b0;
      else if (commit && lat_a_q == 5'h11)    done_q <= 1'b0;

      if (load)         dz_q <= 1'b0;
      else if (load_dz) dz_q <= 1'b1;

      if (load) begin
        acc_q <= {32'd0, a_q};
        wb_q  <= b_q;
        wop_q <= op_q;
        ctr_q <= 5'd0;
      end else if (load_dz) begin
        acc_q <= {a_q, 32'hFFFF_FFFF};
      end else if (state_q == StRun) begin
        acc_q <= wop_q ? div_next : mul_next;
        ctr_q <= ctr_q + 5'd1;
      end

      if (state_q == StFin) r_q <= acc_q;
    end
  end

  assign busy  = (state_q != StIdle);
  assign irq_n = ~(done_q & irq_en_q);

  always_comb begin
    bus.bus_dati = 8'hFF;
    if (bus.bus_ce) begin
      if (!bus.bus_a[4]) begin
        if (bus.bus_a[3])      bus.bus_dati = r_q[{bus.bus_a[2:0], 3'b000} +: 8];
        else if (bus.bus_a[2]) bus.bus_dati = b_q[{bus.bus_a[1:0], 3'b000} +: 8];
        else                   bus.bus_dati = a_q[{bus.bus_a[1:0], 3'b000} +: 8];
      end else if (bus.bus_a == 5'h10) begin
        bus.bus_dati = 8'h00;
      end else if (bus.bus_a == 5'h11) begin
        bus.bus_dati = {5'd0, done_q, dz_q, busy};
      end
    end
  end

endmodule
